mod_updown_counter: RTL and testbench

- Parametrised successor to the team's fixed-modulus counter.
- Counts up or down over the range 0..max_value and wraps at either end.
  - max_value is runtime-programmable; a parameter supplies the value used after reset.
- Adds synchronous clear, parallel load, a terminal-count flag, a registered wrap pulse and a cascade carry output, so several instances can be chained into wider timebases (e.g. seconds/minutes/hours dividers).

---
 rtl/counter_pkg.sv | 57 +++++
 rtl/mod_updown_counter.sv | 70 +++++++
 tb/tb_mod_updown_counter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encoding and
// the next-count/terminal-count rules, computed at the widest supported width.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter any variant may instantiate; narrower users zero-extend.
  localparam int unsigned CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W-1:0] cnt_word_t;

  typedef struct packed {
    logic      wrap;
    cnt_word_t count;
  } count_step_t;

  // One enabled count step. Operands are at most 2^W-1 for the caller's W,
  // so q+1 (only taken when q < max_q) and q-1 (only when q > 0) never leave W bits.
  function automatic count_step_t next_count(
    input cnt_word_t q,
    input cnt_word_t max_q,
    input logic      up_dn
  );
    count_step_t s;
    s.count = q;
    s.wrap  = 1'b0;
    if (up_dn == DIR_UP) begin
      if (q >= max_q) begin
        s.count = '0;
        s.wrap  = 1'b1;
      end else begin
        s.count = q + cnt_word_t'(1);
      end
    end else begin
      if (q == '0) begin
        s.count = max_q;
        s.wrap  = 1'b1;
      end else if (q > max_q) begin
        // modulus was lowered below the current count: snap back without a wrap
        s.count = max_q;
      end else begin
        s.count = q - cnt_word_t'(1);
      end
    end
    return s;
  endfunction

  function automatic logic is_terminal(
    input cnt_word_t q,
    input cnt_word_t max_q,
    input logic      up_dn
  );
    return (up_dn == DIR_UP) ? (q >= max_q) : (q == '0);
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Runtime-programmable modulo up/down counter with clear, clamped load,
// terminal count, registered wrap pulse and cascade carry for chaining.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned MAX_DEFAULT = 53
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             carry_in,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] max_q,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(MAX_DEFAULT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q_q, max_q_d;
  logic             wrap_q, wrap_d;
  logic             advance;
  count_step_t      step;

  assign advance = enable && carry_in;

  always_comb begin
    step    = next_count(cnt_word_t'(cnt_q), cnt_word_t'(max_q_q), up_dn);
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    max_q_d = mod_wr ? mod_value : max_q_q;
    // load clamps against the modulus in force this cycle, not a concurrent write
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_value > max_q_q) ? max_q_q : load_value;
    end else if (advance) begin
      cnt_d  = WIDTH'(step.count);
      wrap_d = step.wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      max_q_q <= MAX_RST;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      max_q_q <= max_q_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q         = cnt_q;
  assign max_q     = max_q_q;
  assign wrap      = wrap_q;
  assign tc        = is_terminal(cnt_word_t'(cnt_q), cnt_word_t'(max_q_q), up_dn);
  assign carry_out = tc && advance;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: single instance plus a two-stage cascade.
module tb_mod_updown_counter;

  logic       clk;
  logic       reset, enable, carry_in, up_dn, clear, load, mod_wr;
  logic [5:0] load_value, mod_value;
  logic [5:0] q, max_q;
  logic       tc, carry_out, wrap;

  logic       c_reset;
  logic [3:0] s0_q, s0_max, s1_q, s1_max;
  logic       s0_tc, s0_carry, s0_wrap, s1_tc, s1_carry, s1_wrap;

  int checks = 0;
  int errors = 0;

  mod_updown_counter #(.WIDTH(6), .MAX_DEFAULT(53)) dut (
    .clk(clk), .reset(reset), .enable(enable), .carry_in(carry_in), .up_dn(up_dn),
    .clear(clear), .load(load), .load_value(load_value), .mod_wr(mod_wr),
    .mod_value(mod_value), .q(q), .max_q(max_q), .tc(tc), .carry_out(carry_out),
    .wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_DEFAULT(9)) stage0 (
    .clk(clk), .reset(c_reset), .enable(1'b1), .carry_in(1'b1), .up_dn(1'b1),
    .clear(1'b0), .load(1'b0), .load_value(4'd0), .mod_wr(1'b0), .mod_value(4'd0),
    .q(s0_q), .max_q(s0_max), .tc(s0_tc), .carry_out(s0_carry), .wrap(s0_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_DEFAULT(5)) stage1 (
    .clk(clk), .reset(c_reset), .enable(1'b1), .carry_in(s0_carry), .up_dn(1'b1),
    .clear(1'b0), .load(1'b0), .load_value(4'd0), .mod_wr(1'b0), .mod_value(4'd0),
    .q(s1_q), .max_q(s1_max), .tc(s1_tc), .carry_out(s1_carry), .wrap(s1_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; carry_in = 1; up_dn = 1; clear = 0; load = 0;
    load_value = 0; mod_wr = 0; mod_value = 0; c_reset = 1;
    tick(); tick();
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (max_q !== 6'd53) begin errors++; $display("FAIL reset_max got=%0d exp=53", max_q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    reset = 0;
  endtask

  task automatic test_up_count();
    int wraps = 0;
    logic [5:0] eq;
    enable = 1; carry_in = 1; up_dn = 1;
    for (int i = 0; i < 56; i++) begin
      eq = (i <= 53) ? 6'(i) : 6'(i - 54);
      checks++; if (q !== eq) begin errors++; $display("FAIL up_q i=%0d got=%0d exp=%0d", i, q, eq); end
      checks++; if (tc !== (eq == 6'd53)) begin errors++; $display("FAIL up_tc i=%0d got=%b", i, tc); end
      checks++; if (carry_out !== (eq == 6'd53)) begin errors++; $display("FAIL up_carry i=%0d got=%b", i, carry_out); end
      checks++; if (wrap !== (i == 54)) begin errors++; $display("FAIL up_wrap i=%0d got=%b", i, wrap); end
      if (wrap === 1'b1) wraps++;
      tick();
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_down_count();
    logic [5:0] eq;
    clear = 1; tick(); clear = 0;
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL clear_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL clear_wrap got=%b exp=0", wrap); end
    up_dn = 0; #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc_at0 got=%b exp=1", tc); end
    tick();
    checks++; if (q !== 6'd53) begin errors++; $display("FAIL dn_wrap_q got=%0d exp=53", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dn_wrap got=%b exp=1", wrap); end
    for (int i = 0; i < 3; i++) begin
      tick();
      eq = 6'(52 - i);
      checks++; if (q !== eq) begin errors++; $display("FAIL dn_q got=%0d exp=%0d", q, eq); end
      checks++; if (wrap !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL dn_flags wrap=%b tc=%b exp=0,0", wrap, tc); end
    end
  endtask

  task automatic test_load();
    enable = 0; up_dn = 1;
    load = 1; load_value = 6'd60; tick();
    checks++; if (q !== 6'd53) begin errors++; $display("FAIL load_clamp got=%0d exp=53", q); end
    load_value = 6'd10; tick();
    checks++; if (q !== 6'd10) begin errors++; $display("FAIL load_10 got=%0d exp=10", q); end
    clear = 1; load_value = 6'd7; tick();
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL clear_over_load got=%0d exp=0", q); end
    clear = 0; load_value = 6'd53; tick(); load = 0;
    enable = 1; carry_in = 0; #1;
    checks++; if (tc !== 1'b1 || carry_out !== 1'b0) begin errors++; $display("FAIL hold_gate tc=%b carry=%b exp=1,0", tc, carry_out); end
    tick();
    checks++; if (q !== 6'd53 || wrap !== 1'b0) begin errors++; $display("FAIL hold q=%0d wrap=%b exp=53,0", q, wrap); end
    carry_in = 1; #1;
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_out got=%b exp=1", carry_out); end
    enable = 0;
  endtask

  task automatic test_runtime_mod();
    load = 1; load_value = 6'd40; tick(); load = 0;
    mod_wr = 1; mod_value = 6'd20; tick(); mod_wr = 0;
    checks++; if (max_q !== 6'd20 || q !== 6'd40) begin errors++; $display("FAIL modwr max=%0d q=%0d exp=20,40", max_q, q); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL mod_tc_above got=%b exp=1", tc); end
    enable = 1; tick(); enable = 0;
    checks++; if (q !== 6'd0 || wrap !== 1'b1) begin errors++; $display("FAIL mod_up q=%0d wrap=%b exp=0,1", q, wrap); end
    mod_wr = 1; mod_value = 6'd53; tick(); mod_wr = 0;
    load = 1; load_value = 6'd40; tick(); load = 0;
    mod_wr = 1; mod_value = 6'd20; tick(); mod_wr = 0;
    up_dn = 0; enable = 1; tick();
    checks++; if (q !== 6'd20 || wrap !== 1'b0) begin errors++; $display("FAIL mod_dn q=%0d wrap=%b exp=20,0", q, wrap); end
    tick();
    checks++; if (q !== 6'd19) begin errors++; $display("FAIL mod_dn_next got=%0d exp=19", q); end
    up_dn = 1; mod_wr = 1; mod_value = 6'd10; tick(); mod_wr = 0;
    checks++; if (q !== 6'd20 || max_q !== 6'd10) begin errors++; $display("FAIL old_max_count q=%0d max=%0d exp=20,10", q, max_q); end
    tick();
    checks++; if (q !== 6'd0 || wrap !== 1'b1) begin errors++; $display("FAIL new_max_count q=%0d wrap=%b exp=0,1", q, wrap); end
    enable = 0; mod_wr = 1; mod_value = 6'd50; load = 1; load_value = 6'd45; tick();
    mod_wr = 0; load = 0;
    checks++; if (q !== 6'd10 || max_q !== 6'd50) begin errors++; $display("FAIL load_old_max q=%0d max=%0d exp=10,50", q, max_q); end
  endtask

  task automatic test_edge_moduli();
    mod_wr = 1; mod_value = 6'd0; tick(); mod_wr = 0;
    enable = 1; up_dn = 1; tick();
    checks++; if (q !== 6'd0 || wrap !== 1'b1) begin errors++; $display("FAIL max0_up1 q=%0d wrap=%b exp=0,1", q, wrap); end
    tick();
    checks++; if (q !== 6'd0 || wrap !== 1'b1) begin errors++; $display("FAIL max0_up2 q=%0d wrap=%b exp=0,1", q, wrap); end
    up_dn = 0; tick();
    checks++; if (q !== 6'd0 || wrap !== 1'b1 || tc !== 1'b1) begin errors++; $display("FAIL max0_dn q=%0d wrap=%b tc=%b exp=0,1,1", q, wrap, tc); end
    enable = 0; mod_wr = 1; mod_value = 6'd63; tick(); mod_wr = 0;
    load = 1; load_value = 6'd63; tick(); load = 0;
    checks++; if (q !== 6'd63) begin errors++; $display("FAIL full_load got=%0d exp=63", q); end
    enable = 1; up_dn = 1; tick();
    checks++; if (q !== 6'd0 || wrap !== 1'b1) begin errors++; $display("FAIL full_up q=%0d wrap=%b exp=0,1", q, wrap); end
    up_dn = 0; tick();
    checks++; if (q !== 6'd63 || wrap !== 1'b1) begin errors++; $display("FAIL full_dn q=%0d wrap=%b exp=63,1", q, wrap); end
  endtask

  task automatic test_reset_priority();
    reset = 1; load = 1; load_value = 6'd7; mod_wr = 1; mod_value = 6'd3; enable = 1;
    tick();
    reset = 0; load = 0; mod_wr = 0; enable = 0;
    checks++; if (q !== 6'd0) begin errors++; $display("FAIL rstpri_q got=%0d exp=0", q); end
    checks++; if (max_q !== 6'd53) begin errors++; $display("FAIL rstpri_max got=%0d exp=53", max_q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rstpri_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_cascade();
    logic [3:0] e0, e1;
    c_reset = 1; tick(); c_reset = 0;
    checks++; if (s0_q !== 4'd0 || s1_q !== 4'd0 || s0_max !== 4'd9 || s1_max !== 4'd5) begin
      errors++; $display("FAIL casc_reset s0=%0d s1=%0d m0=%0d m1=%0d", s0_q, s1_q, s0_max, s1_max);
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      e0 = 4'(k % 10);
      e1 = 4'((k / 10) % 6);
      checks++; if (s0_q !== e0 || s1_q !== e1) begin
        errors++; $display("FAIL casc k=%0d s0=%0d s1=%0d exp=%0d,%0d", k, s0_q, s1_q, e0, e1);
      end
      checks++; if (s1_wrap !== (k == 60)) begin errors++; $display("FAIL casc_wrap k=%0d got=%b", k, s1_wrap); end
      checks++; if (s1_carry !== (k == 59)) begin errors++; $display("FAIL casc_carry k=%0d got=%b", k, s1_carry); end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_runtime_mod();
    test_edge_moduli();
    test_reset_priority();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
